// File: rtl/phased_tick_gen_pkg.sv
// phased_tick_pkg: config address map, config FSM states and period floor for phased_tick_gen
package phased_tick_pkg;
  localparam int MIN_PERIOD = 2;
  typedef enum logic {IDLE, PENDING} cfg_state_t;
  function automatic int addr_period(input int n_ch);
    return n_ch;
  endfunction
  function automatic int addr_commit(input int n_ch);
    return n_ch + 1;
  endfunction
endpackage

// File: rtl/phased_tick_gen_chan.sv
// phased_tick_chan: one tick channel (phase match, output register; PHASED_TICK_PULSE_STRETCH_EN adds a PULSE_W stretch counter)
module phased_tick_chan #(
  parameter int CNT_W   = 21,
  parameter int PULSE_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] phase,
  output logic             pulse_d,
  output logic             pulse
);
  logic hit;
  if (PULSE_W < 1 || PULSE_W > 255) begin : g_bad_pulse_w
    $error("phased_tick_chan: PULSE_W must be 1..255");
  end
  assign hit = en && cnt == phase;
`ifdef PHASED_TICK_PULSE_STRETCH_EN
  logic [7:0] left, left_d;
  // A match (re)loads the width, enabled clocks count it down, disabled clocks freeze it
  always_comb begin
    left_d  = !en ? left : hit ? 8'(PULSE_W) : left != '0 ? left - 8'd1 : left;
    pulse_d = left_d != '0;
  end
  // Stretch counter register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) left <= '0;
    else left <= left_d;
`else
  assign pulse_d = hit;
`endif
  // Registered tick output, one clock after the match
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pulse <= 1'b0;
    else pulse <= pulse_d;
endmodule

// File: rtl/phased_tick_gen.sv
// phased_tick_gen: N-channel phased tick generator, config committed at frame wrap; PHASED_TICK_PULSE_STRETCH_EN stretches ticks to PULSE_W clocks
module phased_tick_gen
  import phased_tick_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 21,
  parameter int DEF_PERIOD = 2000000,
  parameter int PULSE_W    = 1,
  parameter int ADDR_W     = $clog2(N_CH + 2)
) (
  input  logic              F50M,
  input  logic              RESET,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [CNT_W-1:0]  cfg_data,
  output logic [N_CH-1:0]   pulse,
  output logic              pulse_any,
  output logic              frame_start,
  output logic [CNT_W-1:0]  cnt_o
);
  localparam logic [CNT_W-1:0]  MIN_P = CNT_W'(MIN_PERIOD);
  localparam logic [ADDR_W-1:0] A_PER = ADDR_W'(addr_period(N_CH));
  localparam logic [ADDR_W-1:0] A_COM = ADDR_W'(addr_commit(N_CH));
  cfg_state_t state, state_d;
  logic [CNT_W-1:0] cnt, period_r, period_s;
  logic [N_CH-1:0] pulse_d;
  logic wrap, wr, apply;
  if (N_CH < 1 || N_CH > 16 || DEF_PERIOD < MIN_PERIOD || longint'(DEF_PERIOD) >= (longint'(1) << CNT_W)) begin : g_bad_cfg
    $error("phased_tick_gen: N_CH or DEF_PERIOD out of range");
  end
  // Wrap detect, accepted-write strobe and commit handshake; writes are blocked while a commit waits
  always_comb begin
    cfg_ready = state == IDLE;
    wrap      = en && cnt == period_r - CNT_W'(1);
    wr        = cfg_valid && cfg_ready;
    apply     = state == PENDING && wrap;
    state_d   = state == IDLE ? (wr && cfg_addr == A_COM ? PENDING : IDLE) : (wrap ? IDLE : PENDING);
  end
  // Config FSM state register
  always_ff @(posedge F50M or negedge RESET)
    if (!RESET) state <= IDLE;
    else state <= state_d;
  // Frame counter, period shadow/active pair (floored at commit) and aligned frame/any flags
  always_ff @(posedge F50M or negedge RESET)
    if (!RESET) begin
      cnt         <= '0;
      period_r    <= CNT_W'(DEF_PERIOD);
      period_s    <= CNT_W'(DEF_PERIOD);
      frame_start <= 1'b0;
      pulse_any   <= 1'b0;
    end else begin
      if (en) cnt <= wrap ? '0 : cnt + CNT_W'(1);
      if (wr && cfg_addr == A_PER) period_s <= cfg_data;
      if (apply) period_r <= period_s < MIN_P ? MIN_P : period_s;
      frame_start <= wrap;
      pulse_any   <= |pulse_d;
    end
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    localparam logic [CNT_W-1:0] DEF_PH = CNT_W'((k + 1) * DEF_PERIOD / N_CH - 1);
    logic [CNT_W-1:0] phase_r, phase_s;
    // Phase shadow takes writes; the active phase copies it only at the committed wrap
    always_ff @(posedge F50M or negedge RESET)
      if (!RESET) begin
        phase_r <= DEF_PH;
        phase_s <= DEF_PH;
      end else begin
        if (wr && cfg_addr == ADDR_W'(k)) phase_s <= cfg_data;
        if (apply) phase_r <= phase_s;
      end
    phased_tick_chan #(.CNT_W(CNT_W), .PULSE_W(PULSE_W)) u_chan (
      .clk(F50M), .rst_n(RESET), .en(en), .cnt(cnt), .phase(phase_r),
      .pulse_d(pulse_d[k]), .pulse(pulse[k])
    );
  end
  assign cnt_o = cnt;
endmodule

// File: tb/tb_phased_tick_gen.sv
// tb_phased_tick_gen: scoreboard bench for phased_tick_gen with N_CH=4, DEF_PERIOD=20
module tb_phased_tick_gen;
  logic F50M = 1'b0;
  logic RESET = 1'b0;
  logic en = 1'b1;
  logic cfg_valid = 1'b0;
  logic cfg_ready;
  logic [2:0] cfg_addr = '0;
  logic [20:0] cfg_data = '0;
  logic [3:0] pulse;
  logic pulse_any, frame_start;
  logic [20:0] cnt_o;
  int errors = 0;
  int checks = 0;
  typedef struct {logic [3:0] p; logic fs; logic [20:0] c;} ev_t;
  ev_t exp_q[$];
  ev_t e;

  phased_tick_gen #(.N_CH(4), .CNT_W(21), .DEF_PERIOD(20), .PULSE_W(1)) dut (
    .F50M(F50M), .RESET(RESET), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .pulse(pulse), .pulse_any(pulse_any),
    .frame_start(frame_start), .cnt_o(cnt_o)
  );

  always #5 F50M = ~F50M;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push(input logic [3:0] p, input logic fs, input logic [20:0] c);
    exp_q.push_back('{p, fs, c});
  endtask

  // Default frame: phases 4,9,14,19 seen one clock later; wrap rides with channel 3
  task automatic push_def();
    push(4'b0001, 1'b0, 21'd5);
    push(4'b0010, 1'b0, 21'd10);
    push(4'b0100, 1'b0, 21'd15);
    push(4'b1000, 1'b1, 21'd0);
  endtask

  // Period-10 frame with phase1=2 and channel 0 visible at c0; channels 2,3 out of range
  task automatic push_p10(input logic [20:0] c0);
    push(4'b0010, 1'b0, 21'd3);
    push(4'b0001, 1'b0, c0);
    push(4'b0000, 1'b1, 21'd0);
  endtask

  task automatic wait_cnt(input logic [20:0] v);
    bit hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge F50M);
      hit = cnt_o == v;
    end
    if (!hit) begin
      errors++;
      checks++;
      $display("FAIL wait_cnt: cnt_o=%0d never reached %0d", cnt_o, v);
    end
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [20:0] d);
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_data  = d;
    @(negedge F50M);
    cfg_valid = 1'b0;
  endtask

  // Monitor: every tick or frame_start pops the next expected event
  always @(negedge F50M)
    if (RESET && (pulse_any || frame_start)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got pulse=%b fs=%b cnt=%0d, none required", pulse, frame_start, cnt_o);
      end else begin
        e = exp_q.pop_front();
        if ({pulse, pulse_any, frame_start, cnt_o} !== {e.p, |e.p, e.fs, e.c}) begin
          errors++;
          $display("FAIL event: got pulse=%b any=%b fs=%b cnt=%0d, required pulse=%b any=%b fs=%b cnt=%0d",
                   pulse, pulse_any, frame_start, cnt_o, e.p, |e.p, e.fs, e.c);
        end
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge F50M);
    chk("rst_cnt", 32'(cnt_o), 0);
    chk("rst_ready", 32'(cfg_ready), 1);
    chk("rst_pulse", 32'(pulse), 0);
    chk("rst_any", 32'(pulse_any), 0);
    chk("rst_fs", 32'(frame_start), 0);
    repeat (3) push_def();
    RESET = 1'b1;
    repeat (2) wait_cnt(21'd19);
    wait_cnt(21'd6);
    cfg_write(3'd1, 21'd2);
    cfg_write(3'd4, 21'd10);
    cfg_write(3'd5, 21'd0);
    chk("pending_ready", 32'(cfg_ready), 0);
    wait_cnt(21'd19);
    chk("pending_at_wrap", 32'(cfg_ready), 0);
    push_p10(21'd5);
    push_p10(21'd5);
    @(negedge F50M);
    chk("ready_after_commit", 32'(cfg_ready), 1);
    chk("new_frame_cnt", 32'(cnt_o), 0);
    wait_cnt(21'd9);
    wait_cnt(21'd1);
    cfg_write(3'd0, 21'd7);
    wait_cnt(21'd9);
    cfg_write(3'd5, 21'd0);
    chk("pending_after_wrap_commit", 32'(cfg_ready), 0);
    push_p10(21'd5);
    push_p10(21'd8);
    push_p10(21'd8);
    wait_cnt(21'd9);
    chk("still_pending", 32'(cfg_ready), 0);
    wait_cnt(21'd5);
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge F50M);
      chk("hold_cnt", 32'(cnt_o), 5);
    end
    en = 1'b1;
    wait_cnt(21'd1);
    cfg_write(3'd4, 21'd0);
    cfg_write(3'd5, 21'd0);
    wait_cnt(21'd0);
    push(4'b0000, 1'b1, 21'd0);
    push(4'b0000, 1'b1, 21'd0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge F50M);
      chk("clamp_cnt", 32'(cnt_o), i % 2);
    end
    en = 1'b0;
    cfg_write(3'd4, 21'd8);
    cfg_write(3'd5, 21'd0);
    chk("hold_pending", 32'(cfg_ready), 0);
    repeat (3) @(negedge F50M);
    chk("pending_en_low", 32'(cfg_ready), 0);
    chk("pending_cnt", 32'(cnt_o), 1);
    #2 RESET = 1'b0;
    #1;
    chk("async_rst_cnt", 32'(cnt_o), 0);
    chk("async_rst_ready", 32'(cfg_ready), 1);
    chk("async_rst_pulse", 32'(pulse), 0);
    chk("async_rst_any", 32'(pulse_any), 0);
    chk("async_rst_fs", 32'(frame_start), 0);
    @(negedge F50M);
    RESET = 1'b1;
    en = 1'b1;
    push_def();
    push_def();
    repeat (2) wait_cnt(21'd19);
    repeat (2) @(negedge F50M);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
